// File: rtl/prog_mem_loader_if.sv
// Host-load and CPU-read bus of the program memory loader.
// The master side is the host/CPU. The slave side is prog_mem_loader.
interface prog_mem_loader_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    // Host byte stream
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              load_done;

    // CPU read port
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_err;

    // Status
    logic              cpu_run;
    logic              busy;
    logic              ovf;
    logic [ADDR_W-1:0] load_count;

    modport master (
        output load_valid, load_data, load_done, rd_req, rd_addr,
        input  load_ready, rd_data, rd_valid, rd_err, cpu_run, busy, ovf, load_count
    );

    modport slave (
        input  load_valid, load_data, load_done, rd_req, rd_addr,
        output load_ready, rd_data, rd_valid, rd_err, cpu_run, busy, ovf, load_count
    );
endinterface

// File: rtl/prog_mem_loader.sv
// Program memory and loader that sits in front of the CPU fetch path.
// After reset the block zeroes the memory (CLEAR). It then accepts a host
// byte stream (LOAD) and finally serves 1-cycle-latency CPU reads (RUN).
module prog_mem_loader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 9
) (
    input  logic              clock,
    input  logic              reset,
    prog_mem_loader_if.slave  bus
);
    // Pointers carry one extra bit so that DEPTH == 2**ADDR_W compares without wrapping
    localparam int PTR_W = ADDR_W + 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);
    // load_count saturates at DEPTH, or at the largest value ADDR_W bits can hold
    localparam logic [ADDR_W-1:0] CNT_MAX =
        (DEPTH > (2**ADDR_W - 1)) ? ADDR_W'(2**ADDR_W - 1) : ADDR_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    state_e            state_q;
    logic [PTR_W-1:0]  clr_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [ADDR_W-1:0] load_count_q;
    logic              load_ready_q;
    logic              busy_q;
    logic              cpu_run_q;
    logic              ovf_q;
    logic              rd_valid_q;
    logic              rd_err_q;
    logic [DATA_W-1:0] rd_data_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic [PTR_W-1:0]  wr_ptr_d;
    logic              rd_in_range;
    logic [IDX_W-1:0]  rd_idx;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // Handshake decode and selection of the memory write port
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
        mem_we      = 1'b0;
        mem_waddr   = '0;
        mem_wdata   = '0;
        accept      = (state_q == ST_LOAD) && bus.load_valid && load_ready_q;
        wr_ptr_d    = wr_ptr_q + PTR_W'(1);
        rd_in_range = {1'b0, bus.rd_addr} < DEPTH_P;
        rd_idx      = bus.rd_addr[IDX_W-1:0];
        if (!reset) begin
            if (state_q == ST_CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q[IDX_W-1:0];
            end else if (accept) begin
                mem_we    = 1'b1;
                mem_waddr = wr_ptr_q[IDX_W-1:0];
                mem_wdata = bus.load_data;
            end
        end
    end

    // Memory array write port
    always_ff @(posedge clock) begin
        // NOTE: the array has no reset; the CLEAR state zeroes it one word per cycle, so it can map onto plain RAM.
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Control FSM with registered outputs and the registered read path
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_CLEAR;
            clr_ptr_q    <= '0;
            wr_ptr_q     <= '0;
            load_count_q <= '0;
            load_ready_q <= 1'b0;
            busy_q       <= 1'b1;
            cpu_run_q    <= 1'b0;
            ovf_q        <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_err_q     <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments, so every register here updates from values seen before the edge.
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            case (state_q)
                ST_CLEAR: begin
                    clr_ptr_q <= clr_ptr_q + PTR_W'(1);
                    if (clr_ptr_q == LAST_P) begin
                        state_q      <= ST_LOAD;
                        busy_q       <= 1'b0;
                        load_ready_q <= (wr_ptr_q < DEPTH_P);
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        wr_ptr_q     <= wr_ptr_d;
                        load_ready_q <= (wr_ptr_d < DEPTH_P);
                        if (load_count_q < CNT_MAX) begin
                            load_count_q <= load_count_q + ADDR_W'(1);
                        end
                    end
                    if (bus.load_valid && !load_ready_q) begin
                        ovf_q <= 1'b1;
                    end
                    // A byte accepted in the same cycle as load_done has already been written above
                    if (bus.load_done) begin
                        state_q      <= ST_RUN;
                        cpu_run_q    <= 1'b1;
                        load_ready_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (bus.rd_req) begin
                        rd_valid_q <= 1'b1;
                        if (rd_in_range) begin
                            rd_data_q <= mem[rd_idx];
                        end else begin
                            rd_data_q <= '0;
                            rd_err_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                end
            endcase
        end
    end

    assign bus.load_ready = load_ready_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_err     = rd_err_q;
    assign bus.cpu_run    = cpu_run_q;
    assign bus.busy       = busy_q;
    assign bus.ovf        = ovf_q;
    assign bus.load_count = load_count_q;
endmodule

// File: tb/tb_prog_mem_loader.sv
// Bench for prog_mem_loader: random load/read stimulus against an array model,
// with a read scoreboard drained by an independent monitor.
module tb_prog_mem_loader;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 9;

    logic clock = 1'b0;
    logic reset = 1'b0;

    prog_mem_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    prog_mem_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              err;
    } rd_exp_t;

    rd_exp_t exp_q[$];

    // Reference model: contents, bytes accepted, overflow flag, phase
    logic [DATA_W-1:0] model_mem [DEPTH];
    int                model_count;
    bit                model_ovf;
    bit                model_run;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: every rd_valid pulse must match the oldest outstanding read
    always @(negedge clock) begin
        if (bus.rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_valid_unexpected actual=1 required=0 t=%0t", $time);
            end else begin
                rd_exp_t e;
                e = exp_q.pop_front();
                check("rd_data", 32'(bus.rd_data), 32'(e.data));
                check("rd_err", 32'(bus.rd_err), 32'(e.err));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Reset (optionally with a read request in the same cycle), then time CLEAR
    task automatic do_reset(input bit rd_inflight);
        int cnt;
        reset          = 1'b1;
        bus.rd_req     = rd_inflight;
        bus.rd_addr    = 8'($urandom_range(0, DEPTH - 1));
        bus.load_valid = 1'($urandom_range(0, 1));
        bus.load_data  = 8'($urandom);
        bus.load_done  = 1'b0;
        @(negedge clock);
        reset          = 1'b0;
        bus.rd_req     = 1'b0;
        bus.load_valid = 1'b0;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        model_count = 0;
        model_ovf   = 1'b0;
        model_run   = 1'b0;
        check("rst_busy", 32'(bus.busy), 32'd1);
        check("rst_load_ready", 32'(bus.load_ready), 32'd0);
        check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst_rd_err", 32'(bus.rd_err), 32'd0);
        check("rst_rd_data", 32'(bus.rd_data), 32'd0);
        check("rst_cpu_run", 32'(bus.cpu_run), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        check("rst_load_count", 32'(bus.load_count), 32'd0);
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.busy !== 1'b1) break;
            cnt++;
        end
        check("clear_cycles", 32'(cnt), 32'(DEPTH));
        check("load_ready_after_clear", 32'(bus.load_ready), 32'd1);
        check("cpu_run_in_load", 32'(bus.cpu_run), 32'd0);
    endtask

    // One LOAD cycle: optional byte offer and optional load_done
    task automatic send(input logic [DATA_W-1:0] d, input bit valid, input bit done);
        bus.load_valid = valid;
        bus.load_data  = d;
        bus.load_done  = done;
        if (valid) begin
            if (model_count < DEPTH) begin
                model_mem[model_count] = d;
                model_count++;
            end else begin
                model_ovf = 1'b1;
            end
        end
        if (done) model_run = 1'b1;
        @(negedge clock);
        bus.load_valid = 1'b0;
        bus.load_done  = 1'b0;
        check("load_ready", 32'(bus.load_ready), 32'(!model_run && (model_count < DEPTH)));
        check("ovf", 32'(bus.ovf), 32'(model_ovf));
        check("load_count", 32'(bus.load_count), 32'(model_count));
        check("cpu_run", 32'(bus.cpu_run), 32'(model_run));
    endtask

    // Present one read for one cycle; rd_req stays high for back-to-back use
    task automatic rd(input logic [ADDR_W-1:0] a);
        rd_exp_t e;
        bus.rd_req  = 1'b1;
        bus.rd_addr = a;
        if (model_run) begin
            if (int'(a) < DEPTH) begin
                e.data = model_mem[a];
                e.err  = 1'b0;
            end else begin
                e.data = '0;
                e.err  = 1'b1;
            end
            exp_q.push_back(e);
        end
        @(negedge clock);
    endtask

    task automatic rd_end();
        bus.rd_req = 1'b0;
    endtask

    initial begin
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.load_done  = 1'b0;
        bus.rd_req     = 1'b0;
        bus.rd_addr    = '0;
        idle(2);

        // Zero-byte load: whole memory reads back as zero
        do_reset(1'b0);
        send('0, 1'b0, 1'b1);
        for (int a = 0; a < DEPTH; a++) rd(8'(a));
        rd_end();
        idle(2);

        // Three bytes with gaps, read ignored in LOAD, back-to-back reads, out-of-range
        do_reset(1'b0);
        rd(8'd1);
        rd_end();
        idle(2);
        send(8'h11, 1'b1, 1'b0);
        idle(1);
        send(8'h22, 1'b1, 1'b0);
        idle(2);
        send(8'h33, 1'b1, 1'b0);
        send('0, 1'b0, 1'b1);
        check("count_three", 32'(bus.load_count), 32'd3);
        rd(8'd0); rd(8'd1); rd(8'd2); rd(8'd3);
        rd_end();
        idle(1);
        rd(8'd9); rd(8'hFF);
        rd_end();
        idle(2);

        // Overflow: ten offers into nine words
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) begin
            send(8'hA0 + 8'(i), 1'b1, 1'b0);
            idle($urandom_range(0, 1));
        end
        check("ovf_after_ten", 32'(bus.ovf), 32'd1);
        send('0, 1'b0, 1'b1);
        rd(8'd8);
        rd_end();
        idle(2);

        // load_done together with the only byte
        do_reset(1'b0);
        send(8'h5C, 1'b1, 1'b1);
        rd(8'd0);
        rd_end();
        idle(2);

        // Reset mid-load, then reset with a read in flight
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) send(8'($urandom), 1'b1, 1'b0);
        do_reset(1'b0);
        send('0, 1'b0, 1'b1);
        rd(8'd2);
        rd_end();
        idle(1);
        do_reset(1'b1);
        send('0, 1'b0, 1'b1);
        rd(8'd2);
        rd_end();
        idle(2);

        // Randomized rounds
        for (int r = 0; r < 6; r++) begin
            int  n;
            bit  done_sent;
            do_reset(1'b0);
            n = $urandom_range(0, 12);
            done_sent = 1'b0;
            for (int i = 0; i < n; i++) begin
                idle($urandom_range(0, 2));
                if (i == n - 1 && $urandom_range(0, 1) == 1) begin
                    send(8'($urandom), 1'b1, 1'b1);
                    done_sent = 1'b1;
                end else begin
                    send(8'($urandom), 1'b1, 1'b0);
                end
            end
            if (!done_sent) send(8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
            for (int k = 0; k < 20; k++) begin
                if ($urandom_range(0, 3) == 0) rd(8'($urandom));
                else rd(8'($urandom_range(0, 12)));
                if ($urandom_range(0, 2) == 0) begin
                    rd_end();
                    idle($urandom_range(1, 2));
                end
            end
            rd_end();
            idle(3);
        end

        idle(3);
        check("pending_reads", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
